seg_scan_capture: RTL and testbench

- Receive-side counterpart of the stopwatch display driver.
- Samples the multiplexed 12-bit display bus (8 active-low cathode lines plus 4 active-low anode lines) and decodes each lit digit's segment pattern back to a hex nibble.
- Assembles the four nibbles into a 16-bit value and emits one valid strobe per complete scan frame.
- Used for on-board loopback self-check of the display path and as a bench monitor.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg7_to_hex.sv | 23 ++
 rtl/seg_scan_capture.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared display-bus definitions: anode patterns, segment bit positions and
// the active-low seven-segment code table used by both driver and capture.
package seg_pkg;

  localparam int ANODE_MSB = 11;
  localparam int ANODE_LSB = 8;
  localparam int SEG_DP    = 7;
  localparam int SEG_G     = 6;
  localparam int SEG_A     = 0;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  // Every bus bit except DP takes part in the stability check.
  localparam logic [11:0] CHANGE_MASK = 12'hFFF & ~(12'h001 << SEG_DP);

  // Active-low {g,f,e,d,c,b,a}; entry n is the code for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } scan_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern to a hex
// nibble; err_o flags patterns absent from the table (nibble reads 0).
module seg7_to_hex (
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       err_o
);
  import seg_pkg::*;

  logic [15:0] match_s;

  // Table codes are unique, so OR-ing the matched index yields the nibble.
  always_comb begin
    match_s = 16'h0000;
    nib_o   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      match_s[i] = (seg_i == SEG_TABLE[i]);
      nib_o      = nib_o | ({4{match_s[i]}} & 4'(i));
    end
    err_o = ~|match_s;
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples the multiplexed display bus, decodes each settled digit and emits
// one VAL/VALID update per completed four-digit scan frame.
module seg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 1_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] SEG_IN,
  output logic [15:0] VAL,
  output logic        VALID,
  output logic        FRAME_ERR,
  output logic [3:0]  DIGIT_ERR,
  output logic        TIMEOUT
);
  import seg_pkg::*;

  localparam logic [7:0]  SETTLE_N = 8'(SETTLE_CYCLES);
  localparam logic [31:0] STALE_N  = 32'(STALE_CYCLES);

  logic [11:0] sync1_q, s2_q, prev_q;
  scan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cap_an_q, cap_an_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_err_q, shadow_err_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] val_q, val_d;
  logic [3:0]  dig_err_q, dig_err_d;
  logic        frame_err_q, frame_err_d;
  logic        valid_q, valid_d;
  logic [31:0] stale_q, stale_d;
  logic        timeout_q;

  logic [3:0] anode_s;
  logic       an_valid_s;
  logic [1:0] dig_idx_s;
  logic       changed_s;
  logic       capture_s;
  logic       frame_done_s;
  logic [3:0] dec_nib_s;
  logic       dec_err_s;

  assign anode_s   = s2_q[ANODE_MSB:ANODE_LSB];
  assign changed_s = ((s2_q ^ prev_q) & CHANGE_MASK) != 12'h000;

  seg7_to_hex u_dec (
    .seg_i (s2_q[SEG_G:SEG_A]),
    .nib_o (dec_nib_s),
    .err_o (dec_err_s)
  );

  // Exactly one anode low selects a digit; anything else is treated as blank.
  always_comb begin
    an_valid_s = 1'b0;
    dig_idx_s  = 2'd0;
    case (anode_s)
      AN_DIG0: begin an_valid_s = 1'b1; dig_idx_s = 2'd0; end
      AN_DIG1: begin an_valid_s = 1'b1; dig_idx_s = 2'd1; end
      AN_DIG2: begin an_valid_s = 1'b1; dig_idx_s = 2'd2; end
      AN_DIG3: begin an_valid_s = 1'b1; dig_idx_s = 2'd3; end
      default: begin an_valid_s = 1'b0; dig_idx_s = 2'd0; end
    endcase
  end

  // Scan FSM: settle on a stable anode/segment pair, capture once, then wait
  // for the anode to move on. HOLD compares against the captured anode so a
  // segment-only change never triggers a second capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_an_d  = cap_an_q;
    capture_s = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (an_valid_s) begin
          cnt_d   = 8'd1;
          state_d = (SETTLE_N <= 8'd1) ? ST_CAPTURE : ST_SETTLE;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_SETTLE: begin
        if (changed_s || !an_valid_s) begin
          state_d = ST_HUNT;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ((cnt_q + 8'd1) >= SETTLE_N) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        if (an_valid_s) begin
          capture_s = 1'b1;
          cap_an_d  = anode_s;
          state_d   = ST_HOLD;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_HOLD: begin
        if (anode_s != cap_an_q) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Frame assembly and output/timeout next-state. The frame completes the
  // cycle after the capture that fills the mask.
  always_comb begin
    frame_done_s = (mask_q == 4'hF);
    shadow_d     = shadow_q;
    shadow_err_d = shadow_err_q;
    mask_d       = mask_q;
    val_d        = val_q;
    dig_err_d    = dig_err_q;
    frame_err_d  = frame_err_q;
    valid_d      = 1'b0;
    if (frame_done_s) begin
      mask_d      = 4'h0;
      val_d       = shadow_q;
      dig_err_d   = shadow_err_q;
      frame_err_d = |shadow_err_q;
      valid_d     = 1'b1;
    end else if (capture_s) begin
      shadow_d[{dig_idx_s, 2'b00} +: 4] = dec_nib_s;
      shadow_err_d[dig_idx_s]           = dec_err_s;
      mask_d[dig_idx_s]                 = 1'b1;
    end else begin
      mask_d = mask_q;
    end
    if (frame_done_s) begin
      stale_d = 32'd0;
    end else if (stale_q != STALE_N) begin
      stale_d = stale_q + 32'd1;
    end else begin
      stale_d = stale_q;
    end
  end

  // Input synchronizer plus one-cycle history for change detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 12'h000;
      s2_q    <= 12'h000;
      prev_q  <= 12'h000;
    end else begin
      sync1_q <= SEG_IN;
      s2_q    <= sync1_q;
      prev_q  <= s2_q;
    end
  end

  // FSM, settle counter and frame shadow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_HUNT;
      cnt_q        <= 8'd0;
      cap_an_q     <= 4'h0;
      shadow_q     <= 16'h0000;
      shadow_err_q <= 4'h0;
      mask_q       <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_an_q     <= cap_an_d;
      shadow_q     <= shadow_d;
      shadow_err_q <= shadow_err_d;
      mask_q       <= mask_d;
    end
  end

  // Registered outputs and stale-frame watchdog.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      val_q       <= 16'h0000;
      dig_err_q   <= 4'h0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
      stale_q     <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      val_q       <= val_d;
      dig_err_q   <= dig_err_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
      stale_q     <= stale_d;
      timeout_q   <= (stale_d == STALE_N);
    end
  end

  assign VAL       = val_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign DIGIT_ERR = dig_err_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: scans push expected frames, a
// negedge monitor pops and compares on every VALID pulse.
module tb_seg_scan_capture;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [11:0] SEG_IN;
  logic [15:0] VAL;
  logic        VALID;
  logic        FRAME_ERR;
  logic [3:0]  DIGIT_ERR;
  logic        TIMEOUT;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  derr;
    logic        ferr;
  } frame_t;

  frame_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  seg_scan_capture #(.SETTLE_CYCLES(4), .STALE_CYCLES(50)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SEG_IN    (SEG_IN),
    .VAL       (VAL),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .DIGIT_ERR (DIGIT_ERR),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    SEG_IN = {an, 1'b1, seg};
    tick(n);
  endtask

  task automatic blank(input int n);
    SEG_IN = 12'hFFF;
    tick(n);
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] de, input logic fe);
    frame_t f;
    f.val = v; f.derr = de; f.ferr = fe;
    sb.push_back(f);
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic wait_sb(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL %s: %0d frame(s) still pending, expected 0", name, sb.size());
  endtask

  task automatic std_scan(input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
    show(4'b1110, s0, 10);
    show(4'b1101, s1, 10);
    show(4'b1011, s2, 10);
    show(4'b0111, s3, 10);
  endtask

  // Monitor: every VALID pulse must match the oldest expected frame.
  always @(negedge CLK) begin
    frame_t e;
    if (VALID === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: VAL=%h, expected no VALID", VAL);
      end else begin
        e = sb.pop_front();
        check("val", VAL, e.val);
        check("digit_err", {12'h000, DIGIT_ERR}, {12'h000, e.derr});
        check("frame_err", {15'h0000, FRAME_ERR}, {15'h0000, e.ferr});
        check("timeout_on_valid", {15'h0000, TIMEOUT}, 16'h0000);
      end
    end
  end

  initial begin
    RESET  = 1'b1;
    SEG_IN = 12'hFFF;
    tick(3);
    @(negedge CLK);
    check("rst_val", VAL, 16'h0000);
    check("rst_valid", {15'h0000, VALID}, 16'h0000);
    check("rst_ferr", {15'h0000, FRAME_ERR}, 16'h0000);
    check("rst_derr", {12'h000, DIGIT_ERR}, 16'h0000);
    check("rst_timeout", {15'h0000, TIMEOUT}, 16'h0000);
    tick(1);
    RESET = 1'b0;

    // Idle bus: watchdog reaches 50 after 50 non-reset cycles.
    tick(49);
    @(negedge CLK);
    check("timeout_49", {15'h0000, TIMEOUT}, 16'h0000);
    tick(1);
    @(negedge CLK);
    check("timeout_50", {15'h0000, TIMEOUT}, 16'h0001);
    check("timeout_val", VAL, 16'h0000);

    // Resume: basic 3210 frame; TIMEOUT must be low on the VALID cycle.
    expect_frame(16'h3210, 4'b0000, 1'b0);
    std_scan(7'h40, 7'h79, 7'h24, 7'h30);
    wait_sb("frame_3210");
    blank(10);

    // Undecodable digit 2.
    expect_frame(16'h3010, 4'b0100, 1'b1);
    std_scan(7'h40, 7'h79, 7'h7F, 7'h30);
    wait_sb("frame_err_d2");
    blank(10);

    // Digit 0 too short to settle; frame only completes on the later digit 0.
    show(4'b1110, 7'h78, 3);
    blank(5);
    show(4'b1101, 7'h10, 10);
    blank(5);
    show(4'b1011, 7'h08, 10);
    blank(5);
    show(4'b0111, 7'h03, 10);
    blank(5);
    expect_frame(16'hBA9D, 4'b0000, 1'b0);
    show(4'b1110, 7'h21, 10);
    wait_sb("frame_short_d0");
    blank(10);

    // Digit 1 captured twice in one frame: newer value wins.
    expect_frame(16'hFE5C, 4'b0000, 1'b0);
    show(4'b1110, 7'h46, 10);
    show(4'b1101, 7'h79, 10);
    blank(4);
    show(4'b1101, 7'h12, 10);
    show(4'b1011, 7'h06, 10);
    show(4'b0111, 7'h0E, 10);
    wait_sb("frame_recapture");
    blank(10);

    // Segment change under the same anode is not re-captured.
    expect_frame(16'h2648, 4'b0000, 1'b0);
    show(4'b1110, 7'h00, 10);
    show(4'b1101, 7'h19, 10);
    show(4'b1101, 7'h30, 10);
    show(4'b1011, 7'h02, 10);
    show(4'b0111, 7'h24, 10);
    wait_sb("frame_hold");
    blank(10);

    // Reset after three captures discards the partial frame.
    show(4'b1110, 7'h40, 10);
    show(4'b1101, 7'h79, 10);
    show(4'b1011, 7'h24, 10);
    RESET = 1'b1;
    tick(2);
    @(negedge CLK);
    check("midrst_val", VAL, 16'h0000);
    check("midrst_derr", {12'h000, DIGIT_ERR}, 16'h0000);
    check("midrst_ferr", {15'h0000, FRAME_ERR}, 16'h0000);
    check("midrst_timeout", {15'h0000, TIMEOUT}, 16'h0000);
    tick(1);
    RESET  = 1'b0;
    SEG_IN = 12'hFFF;
    tick(5);
    expect_frame(16'hF765, 4'b0000, 1'b0);
    show(4'b0111, 7'h0E, 10);
    blank(5);
    show(4'b1110, 7'h12, 10);
    show(4'b1101, 7'h02, 10);
    show(4'b1011, 7'h78, 10);
    wait_sb("frame_after_reset");
    blank(30);

    check("sb_empty", 16'(sb.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
